// File: rtl/display_scan_mux_if.sv
// -----------------------------------------------------------------------------
// display_scan_mux_if
// Bundles the signals between the clock/alarm logic, the scan multiplexer and
// the seven-segment decoder.
//   master : drives time/alarm values and display controls, observes the
//            scanned decoder inputs and anodes
//   slave  : the scan multiplexer (consumes controls, drives scan outputs)
// Signals:
//   timeHours/timeMinutes    current time (0..23 / 0..59)
//   alarmHours/alarmMinutes  alarm time   (0..23 / 0..59)
//   showAlarm                1 = alarm source, 0 = time source
//   blinkHours/blinkMinutes  blink the hour / minute digit pair
//   set24hours               1 = 24-hour display, 0 = 12-hour display
//   an                       active-low one-hot digit anodes
//   number/tens/hoursPlace   decoder inputs for the digit being shown
// -----------------------------------------------------------------------------
interface display_scan_mux_if;
    logic [5:0] timeHours;
    logic [5:0] timeMinutes;
    logic [5:0] alarmHours;
    logic [5:0] alarmMinutes;
    logic       showAlarm;
    logic       blinkHours;
    logic       blinkMinutes;
    logic       set24hours;
    logic [3:0] an;
    logic [5:0] number;
    logic       tens;
    logic       hoursPlace;

    modport master (
        output timeHours, timeMinutes, alarmHours, alarmMinutes,
        output showAlarm, blinkHours, blinkMinutes, set24hours,
        input  an, number, tens, hoursPlace
    );

    modport slave (
        input  timeHours, timeMinutes, alarmHours, alarmMinutes,
        input  showAlarm, blinkHours, blinkMinutes, set24hours,
        output an, number, tens, hoursPlace
    );
endinterface

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
// Time-multiplexes a 4-digit HH:MM display feeding the seven-segment decoder.
// Every REFRESH_DIV clocks one digit slot elapses; on that tick the registered
// outputs load the anode/decoder settings for the current digit and the digit
// index advances. Handles time/alarm source selection per frame, set-mode
// blinking and leading-zero blanking of the hours-tens digit in 12-hour mode.
// Ports:
//   clk     system clock, rising edge
//   resetN  asynchronous active-low reset
//   bus     display_scan_mux_if.slave (source values, controls, scan outputs)
// -----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  resetN,
    display_scan_mux_if.slave     bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    // The hours-tens digit is dark in 12-hour mode when the displayed value
    // (0 -> 12, 13..23 -> h-12) is a single digit. Out-of-range hours are
    // never blanked.
    function automatic logic lead_zero_blank(input logic [5:0] hours);
        logic blank;
        if ((hours >= 6'd1) && (hours <= 6'd9)) begin
            blank = 1'b1;
        end else if ((hours >= 6'd13) && (hours <= 6'd21)) begin
            blank = 1'b1;
        end else begin
            blank = 1'b0;
        end
        return blank;
    endfunction

    logic [PW-1:0] prescaler_r;
    logic [1:0]    digit_idx_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;
    logic          src_sel_r;
    logic [3:0]    an_r;
    logic [5:0]    number_r;
    logic          tens_r;
    logic          hours_place_r;

    logic          tick_s;
    logic          use_alarm_s;
    logic [5:0]    hours_s;
    logic [5:0]    minutes_s;
    logic [3:0]    an_map_s;
    logic          blank_s;
    logic [3:0]    an_nxt_s;
    logic [5:0]    number_nxt_s;
    logic          tens_nxt_s;
    logic          hours_place_nxt_s;

    assign tick_s = (prescaler_r == PRE_LAST);

    // Digit decode: source selection, anode map, blink and blanking for the
    // digit loaded on the next tick.
    always_comb begin
        // At frame start the new source is taken straight from showAlarm so the
        // whole frame, digit 0 included, shows one source.
        if (digit_idx_r == 2'd0) begin
            use_alarm_s = bus.showAlarm;
        end else begin
            use_alarm_s = src_sel_r;
        end

        if (use_alarm_s) begin
            hours_s   = bus.alarmHours;
            minutes_s = bus.alarmMinutes;
        end else begin
            hours_s   = bus.timeHours;
            minutes_s = bus.timeMinutes;
        end

        an_map_s          = 4'b1111;
        number_nxt_s      = 6'd0;
        tens_nxt_s        = 1'b0;
        hours_place_nxt_s = 1'b0;
        blank_s           = 1'b0;

        case (digit_idx_r)
            2'd0: begin
                an_map_s          = 4'b1110;
                number_nxt_s      = minutes_s;
                tens_nxt_s        = 1'b0;
                hours_place_nxt_s = 1'b0;
                blank_s           = bus.blinkMinutes & blink_phase_r;
            end
            2'd1: begin
                an_map_s          = 4'b1101;
                number_nxt_s      = minutes_s;
                tens_nxt_s        = 1'b1;
                hours_place_nxt_s = 1'b0;
                blank_s           = bus.blinkMinutes & blink_phase_r;
            end
            2'd2: begin
                an_map_s          = 4'b1011;
                number_nxt_s      = hours_s;
                tens_nxt_s        = 1'b0;
                hours_place_nxt_s = 1'b1;
                blank_s           = bus.blinkHours & blink_phase_r;
            end
            2'd3: begin
                an_map_s          = 4'b0111;
                number_nxt_s      = hours_s;
                tens_nxt_s        = 1'b1;
                hours_place_nxt_s = 1'b1;
                blank_s           = (bus.blinkHours & blink_phase_r) |
                                    (~bus.set24hours & lead_zero_blank(hours_s));
            end
            default: begin
                an_map_s          = 4'b1111;
                number_nxt_s      = 6'd0;
                tens_nxt_s        = 1'b0;
                hours_place_nxt_s = 1'b0;
                blank_s           = 1'b1;
            end
        endcase

        if (blank_s) begin
            an_nxt_s = 4'b1111;
        end else begin
            an_nxt_s = an_map_s;
        end
    end

    // Slot prescaler: free-running 0..REFRESH_DIV-1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prescaler_r <= '0;
        end else if (tick_s) begin
            prescaler_r <= '0;
        end else begin
            prescaler_r <= prescaler_r + 1'b1;
        end
    end

    // Scan state: digit index, frame source latch and free-running blink timer.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            digit_idx_r   <= 2'd0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
            src_sel_r     <= 1'b0;
        end else if (tick_s) begin
            digit_idx_r <= digit_idx_r + 2'd1;
            src_sel_r   <= use_alarm_s;
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + 1'b1;
            end
        end else begin
            digit_idx_r   <= digit_idx_r;
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
            src_sel_r     <= src_sel_r;
        end
    end

    // Output registers: load only on tick edges.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            an_r          <= 4'b1111;
            number_r      <= 6'd0;
            tens_r        <= 1'b0;
            hours_place_r <= 1'b0;
        end else if (tick_s) begin
            an_r          <= an_nxt_s;
            number_r      <= number_nxt_s;
            tens_r        <= tens_nxt_s;
            hours_place_r <= hours_place_nxt_s;
        end else begin
            an_r          <= an_r;
            number_r      <= number_r;
            tens_r        <= tens_r;
            hours_place_r <= hours_place_r;
        end
    end

    assign bus.an         = an_r;
    assign bus.number     = number_r;
    assign bus.tens       = tens_r;
    assign bus.hoursPlace = hours_place_r;

endmodule

// File: tb/tb_display_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_display_scan_mux
// Directed bench for display_scan_mux with REFRESH_DIV=4, BLINK_TICKS=8.
// Outputs are sampled on the falling clock edge; a "tick" below means the
// four clocks that carry the scan to the next digit.
// -----------------------------------------------------------------------------
module tb_display_scan_mux;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    display_scan_mux_if dsm_if ();

    display_scan_mux #(
        .REFRESH_DIV (4),
        .BLINK_TICKS (8)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (dsm_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_an(input string tag, input logic [3:0] exp_an);
        checks++;
        assert (dsm_if.an === exp_an) else begin
            errors++;
            $error("FAIL %s an observed=%b expected=%b", tag, dsm_if.an, exp_an);
        end
    endtask

    task automatic chk_num(input string tag, input logic [5:0] exp_num);
        checks++;
        assert (dsm_if.number === exp_num) else begin
            errors++;
            $error("FAIL %s number observed=%0d expected=%0d", tag, dsm_if.number, exp_num);
        end
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] exp_an,
                             input logic exp_tens, input logic exp_hp,
                             input logic [5:0] exp_num);
        chk_an(tag, exp_an);
        chk_num(tag, exp_num);
        checks++;
        assert (dsm_if.tens === exp_tens) else begin
            errors++;
            $error("FAIL %s tens observed=%b expected=%b", tag, dsm_if.tens, exp_tens);
        end
        checks++;
        assert (dsm_if.hoursPlace === exp_hp) else begin
            errors++;
            $error("FAIL %s hoursPlace observed=%b expected=%b", tag, dsm_if.hoursPlace, exp_hp);
        end
    endtask

    task automatic one_tick();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [3:0] an_tab [4];
        logic [3:0] exp_an;
        int         d;

        an_tab[0] = 4'b1110;
        an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011;
        an_tab[3] = 4'b0111;
        checks = 0;
        errors = 0;

        resetN              = 1'b0;
        dsm_if.timeHours    = 6'd14;
        dsm_if.timeMinutes  = 6'd37;
        dsm_if.alarmHours   = 6'd6;
        dsm_if.alarmMinutes = 6'd45;
        dsm_if.showAlarm    = 1'b0;
        dsm_if.blinkHours   = 1'b0;
        dsm_if.blinkMinutes = 1'b0;
        dsm_if.set24hours   = 1'b1;

        repeat (2) @(negedge clk);
        chk_digit("reset_state", 4'b1111, 1'b0, 1'b0, 6'd0);
        resetN = 1'b1;

        // Three dark cycles, then digit 0 on the fourth edge (tick 0).
        @(negedge clk); chk_an("post_reset_c1", 4'b1111);
        @(negedge clk); chk_an("post_reset_c2", 4'b1111);
        @(negedge clk); chk_an("post_reset_c3", 4'b1111);
        @(negedge clk); chk_digit("first_tick_d0", 4'b1110, 1'b0, 1'b0, 6'd37);

        // Outputs hold between ticks.
        repeat (2) @(negedge clk);
        chk_digit("hold_between_ticks", 4'b1110, 1'b0, 1'b0, 6'd37);
        repeat (2) @(negedge clk);
        chk_digit("t1_d1", 4'b1101, 1'b1, 1'b0, 6'd37);
        one_tick(); chk_digit("t2_d2", 4'b1011, 1'b0, 1'b1, 6'd14);
        one_tick(); chk_digit("t3_d3", 4'b0111, 1'b1, 1'b1, 6'd14);
        one_tick(); chk_digit("t4_d0", 4'b1110, 1'b0, 1'b0, 6'd37);
        one_tick(); chk_digit("t5_d1", 4'b1101, 1'b1, 1'b0, 6'd37);
        one_tick(); chk_digit("t6_d2", 4'b1011, 1'b0, 1'b1, 6'd14);
        one_tick(); chk_digit("t7_d3", 4'b0111, 1'b1, 1'b1, 6'd14);

        // 12-hour leading-zero blanking on digit 3 (ticks 8..23).
        dsm_if.set24hours = 1'b0;
        dsm_if.timeHours  = 6'd9;
        repeat (3) one_tick();
        chk_an("h9_d2_lit", 4'b1011);
        one_tick(); chk_digit("h9_d3_blank", 4'b1111, 1'b1, 1'b1, 6'd9);
        dsm_if.timeHours = 6'd0;
        repeat (4) one_tick(); chk_digit("h0_d3_lit", 4'b0111, 1'b1, 1'b1, 6'd0);
        dsm_if.timeHours = 6'd22;
        repeat (4) one_tick(); chk_digit("h22_d3_lit", 4'b0111, 1'b1, 1'b1, 6'd22);
        dsm_if.timeHours = 6'd13;
        repeat (4) one_tick(); chk_digit("h13_d3_blank", 4'b1111, 1'b1, 1'b1, 6'd13);

        // Minute blinking over ticks 24..55; phase is high for ticks k with (k/8) odd.
        dsm_if.set24hours   = 1'b1;
        dsm_if.timeHours    = 6'd14;
        dsm_if.blinkMinutes = 1'b1;
        for (int k = 24; k < 56; k++) begin
            one_tick();
            d = k % 4;
            if ((d < 2) && (((k / 8) % 2) == 1)) begin
                exp_an = 4'b1111;
            end else begin
                exp_an = an_tab[d];
            end
            chk_digit($sformatf("blink_min_t%0d", k), exp_an, d[0], d[1],
                      (d < 2) ? 6'd37 : 6'd14);
        end
        dsm_if.blinkMinutes = 1'b0;

        // Hour blinking, ticks 56..59 (phase high).
        dsm_if.blinkHours = 1'b1;
        one_tick(); chk_an("blink_hr_d0", 4'b1110);
        one_tick(); chk_an("blink_hr_d1", 4'b1101);
        one_tick(); chk_digit("blink_hr_d2", 4'b1111, 1'b0, 1'b1, 6'd14);
        one_tick(); chk_digit("blink_hr_d3", 4'b1111, 1'b1, 1'b1, 6'd14);
        dsm_if.blinkHours = 1'b0;

        // Mid-frame source change: takes effect at the next frame (ticks 60..65).
        one_tick(); chk_digit("src_t60_d0", 4'b1110, 1'b0, 1'b0, 6'd37);
        dsm_if.showAlarm = 1'b1;
        one_tick(); chk_digit("src_t61_d1", 4'b1101, 1'b1, 1'b0, 6'd37);
        one_tick(); chk_digit("src_t62_d2", 4'b1011, 1'b0, 1'b1, 6'd14);
        one_tick(); chk_digit("src_t63_d3", 4'b0111, 1'b1, 1'b1, 6'd14);
        one_tick(); chk_digit("src_alarm_d0", 4'b1110, 1'b0, 1'b0, 6'd45);
        one_tick(); chk_digit("src_alarm_d1", 4'b1101, 1'b1, 1'b0, 6'd45);

        // Asynchronous reset while digit index is 2.
        #1 resetN = 1'b0;
        #1;
        chk_digit("async_reset", 4'b1111, 1'b0, 1'b0, 6'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk); chk_an("rerun_c1", 4'b1111);
        @(negedge clk); chk_an("rerun_c2", 4'b1111);
        @(negedge clk); chk_an("rerun_c3", 4'b1111);
        @(negedge clk); chk_digit("rerun_first_d0", 4'b1110, 1'b0, 1'b0, 6'd45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Upstream neighbour of the seven-segment decoder (displayDriver).
- Time-multiplexes a 4-digit HH:MM display and selects the time or alarm source.
- Drives the decoder's number/tens/hoursPlace inputs plus the active-low anode lines.
- Handles set-mode blinking and 12-hour leading-zero blanking.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz -> 1 kHz slot rate); must be >= 2
BLINK_TICKS, 250, digit slots per blink half-period (250 ms at defaults); must be >= 1

Ports:
clk  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
timeHours  input  6  current time hours, 0..23
timeMinutes  input  6  current time minutes, 0..59
alarmHours  input  6  alarm hours, 0..23
alarmMinutes  input  6  alarm minutes, 0..59
showAlarm  input  1  1 = display alarm source, 0 = time source
blinkHours  input  1  blink both hour digits (set mode)
blinkMinutes  input  1  blink both minute digits (set mode)
set24hours  input  1  1 = 24-hour display, 0 = 12-hour display
an  output  4  digit anodes, active-low one-hot; an[0] = minutes ones ... an[3] = hours tens
number  output  6  value fed to the decoder (minutes or hours of the selected source)
tens  output  1  1 = decoder shows the tens digit
hoursPlace  output  1  1 = number is an hour value

Behaviour:
- One clock domain, single clock. Reset is asynchronous and active-low (resetN) and applies to every register.
- Reset values:
  - an = 4'b1111 (all digits off), number = 0, tens = 0, hoursPlace = 0.
  - prescaler = 0, digitIdx = 0, blinkCnt = 0, blinkPhase = 0, srcSel = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where prescaler == REFRESH_DIV-1.
- On each tick, at that rising edge:
  - The outputs load for the current digitIdx, then digitIdx increments mod 4.
  - The first tick after reset therefore displays digit 0.
  - Outputs are registered and change only on tick edges, never between ticks.
- Digit map (digitIdx -> an, tens, hoursPlace, number):
  - 0 -> 1110, 0, 0, minutes
  - 1 -> 1101, 1, 0, minutes
  - 2 -> 1011, 0, 1, hours
  - 3 -> 0111, 1, 1, hours
- Source select:
  - srcSel is loaded from showAlarm only on a tick where digitIdx == 0 (frame start).
  - A full 4-digit frame always comes from one source.
  - A mid-frame change of showAlarm takes effect at the next frame.
  - Source values themselves are sampled live at each tick.
- Blink:
  - blinkCnt counts ticks 0..BLINK_TICKS-1. On wrap, blinkPhase toggles.
  - blinkCnt is free-running, independent of the blink inputs.
  - If blinkPhase = 1 and the digit is an hour digit with blinkHours = 1, an loads 4'b1111. number/tens/hoursPlace still load normally.
  - The same rule applies to minute digits with blinkMinutes.
  - Both blink inputs may be set together; each group is handled independently.
- Leading-zero blanking (digitIdx == 3 only, set24hours = 0):
  - The displayed 12-hour value maps 0 -> 12 and 13..23 -> h-12.
  - an loads 4'b1111 when the displayed value is < 10, i.e. hours in {1..9, 13..21}.
  - No blanking when set24hours = 1 (e.g. 05 shows as "05").
- 12/24 conversion itself is done by the decoder; this block always passes the raw hours value.
- Out-of-range inputs (hours > 23, minutes > 59) pass through unchanged; the decoder defines the glyph. No blanking is applied except the rules above.
- Reset mid-operation:
  - Anodes go off immediately (asynchronous).
  - Scanning restarts at digit 0 after a full REFRESH_DIV period following deassertion.
- Single-cycle tick pulse only; no other handshake.

Test Plan:
- REFRESH_DIV=4, BLINK_TICKS=8; release reset -> an=1111 for 3 cycles; at cycle 4 edge: an=1110, tens=0, hoursPlace=0, number=timeMinutes.
- timeHours=14, timeMinutes=37, set24hours=1, 8 ticks -> sequence repeats twice: (1110,0,0,37), (1101,1,0,37), (1011,0,1,14), (0111,1,1,14).
- set24hours=0, timeHours=9 -> digit 3 an=1111. timeHours=0 -> digit 3 an=0111. timeHours=22 -> 0111. timeHours=13 -> 1111.
- blinkMinutes=1, run 32 ticks -> digits 0/1 anodes are 1111 during ticks 8-15 and 24-31. Hour digits unaffected. number/tens still cycle.
- Assert showAlarm on the tick that displays digit 1 -> digits 2/3 of that frame still show timeHours; next frame digit 0 shows alarmMinutes (e.g. 45).
- Assert resetN=0 mid-frame (digitIdx=2) between clock edges -> an=1111 and number=0 immediately. After release, the first lit digit is an=1110.
